// File: rtl/branch_resolve_ex_if.sv
// ID/EX boundary bundle for the branch resolution unit: decode fields in,
// redirect, link and statistics out.
interface branch_resolve_ex_if #(
  parameter int unsigned CNT_W = 16
);
  logic             AnyStall;
  logic             Valid_ID;
  logic [31:0]      Pc_ID;
  logic [15:0]      Imm_ID;
  logic [2:0]       BpCtl_ID;
  logic             Link_ID;
  logic [31:0]      SrcA_ID;
  logic [31:0]      SrcB_ID;
  logic             BranchTaken_EX;
  logic [31:0]      RedirectPc_EX;
  logic             Valid_EX;
  logic [31:0]      LinkVal_EX;
  logic             Link_EX;
  logic [CNT_W-1:0] BranchCnt;
  logic [CNT_W-1:0] TakenCnt;

  modport master (
    output AnyStall, Valid_ID, Pc_ID, Imm_ID, BpCtl_ID, Link_ID, SrcA_ID, SrcB_ID,
    input  BranchTaken_EX, RedirectPc_EX, Valid_EX, LinkVal_EX, Link_EX,
           BranchCnt, TakenCnt
  );

  modport slave (
    input  AnyStall, Valid_ID, Pc_ID, Imm_ID, BpCtl_ID, Link_ID, SrcA_ID, SrcB_ID,
    output BranchTaken_EX, RedirectPc_EX, Valid_EX, LinkVal_EX, Link_EX,
           BranchCnt, TakenCnt
  );
endinterface

// File: rtl/branch_resolve_ex.sv
// EX-stage branch resolution: registers decoded branch info, evaluates the
// condition, issues a single redirect pulse per taken branch and squashes the wrong path.
module branch_resolve_ex #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  branch_resolve_ex_if.slave  bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 16;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_BEQ  = 3'b001,
    OP_BNE  = 3'b010,
    OP_BLEZ = 3'b011,
    OP_BGTZ = 3'b100,
    OP_BLTZ = 3'b101,
    OP_BGEZ = 3'b110,
    OP_JR   = 3'b111
  } bp_op_e;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  bp_op_e           bpctl_q, bpctl_d;
  logic             link_q, link_d;
  logic [XLEN-1:0]  srca_q, srca_d;
  logic [XLEN-1:0]  srcb_q, srcb_d;
  logic             redirect_issued_q, redirect_issued_d;
  logic             squash_pending_q, squash_pending_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             cond_raw_c;
  logic             cond_c;
  logic             taken_c;
  logic             squash_c;
  logic             admit_c;
  logic [XLEN-1:0]  target_c;
  logic [XLEN-1:0]  pc_plus4_c;
  logic             a_zero_c;
  logic             a_neg_c;

  // Condition and target from EX registers; signed compares against zero use sign/zero bits.
  always_comb begin
    a_zero_c   = (srca_q == '0);
    a_neg_c    = srca_q[XLEN-1];
    pc_plus4_c = pc_q + XLEN'(4);
    cond_raw_c = 1'b0;
    unique case (bpctl_q)
      OP_NONE: cond_raw_c = 1'b0;
      OP_BEQ:  cond_raw_c = (srca_q == srcb_q);
      OP_BNE:  cond_raw_c = (srca_q != srcb_q);
      OP_BLEZ: cond_raw_c = a_neg_c | a_zero_c;
      OP_BGTZ: cond_raw_c = ~a_neg_c & ~a_zero_c;
      OP_BLTZ: cond_raw_c = a_neg_c;
      OP_BGEZ: cond_raw_c = ~a_neg_c;
      OP_JR:   cond_raw_c = 1'b1;
      default: cond_raw_c = 1'b0;
    endcase
    if (bpctl_q == OP_JR) begin
      target_c = srca_q;
    end else begin
      target_c = pc_plus4_c + {{(XLEN-IMM_W-2){imm_q[IMM_W-1]}}, imm_q, 2'b00};
    end
    cond_c   = valid_q & cond_raw_c;
    taken_c  = cond_c & ~redirect_issued_q;
    squash_c = taken_c | squash_pending_q;
    admit_c  = bus.Valid_ID & ~squash_c;
  end

  // Next-state: load on advance, hold on stall; flags remember a redirect issued under stall.
  always_comb begin
    valid_d           = valid_q;
    pc_d              = pc_q;
    imm_d             = imm_q;
    bpctl_d           = bpctl_q;
    link_d            = link_q;
    srca_d            = srca_q;
    srcb_d            = srcb_q;
    redirect_issued_d = redirect_issued_q;
    squash_pending_d  = squash_pending_q;
    branch_cnt_d      = branch_cnt_q;
    taken_cnt_d       = taken_cnt_q;
    if (!bus.AnyStall) begin
      valid_d           = admit_c;
      pc_d              = bus.Pc_ID;
      imm_d             = bus.Imm_ID;
      bpctl_d           = admit_c ? bp_op_e'(bus.BpCtl_ID) : OP_NONE;
      link_d            = admit_c & bus.Link_ID;
      srca_d            = bus.SrcA_ID;
      srcb_d            = bus.SrcB_ID;
      redirect_issued_d = 1'b0;
      squash_pending_d  = 1'b0;
      if (valid_q && (bpctl_q != OP_NONE)) begin
        branch_cnt_d = (branch_cnt_q == '1) ? branch_cnt_q : branch_cnt_q + CNT_W'(1);
        if (cond_c) begin
          taken_cnt_d = (taken_cnt_q == '1) ? taken_cnt_q : taken_cnt_q + CNT_W'(1);
        end
      end
    end else if (taken_c) begin
      redirect_issued_d = 1'b1;
      squash_pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q           <= 1'b0;
      pc_q              <= '0;
      imm_q             <= '0;
      bpctl_q           <= OP_NONE;
      link_q            <= 1'b0;
      srca_q            <= '0;
      srcb_q            <= '0;
      redirect_issued_q <= 1'b0;
      squash_pending_q  <= 1'b0;
      branch_cnt_q      <= '0;
      taken_cnt_q       <= '0;
    end else begin
      valid_q           <= valid_d;
      pc_q              <= pc_d;
      imm_q             <= imm_d;
      bpctl_q           <= bpctl_d;
      link_q            <= link_d;
      srca_q            <= srca_d;
      srcb_q            <= srcb_d;
      redirect_issued_q <= redirect_issued_d;
      squash_pending_q  <= squash_pending_d;
      branch_cnt_q      <= branch_cnt_d;
      taken_cnt_q       <= taken_cnt_d;
    end
  end

  assign bus.BranchTaken_EX = taken_c;
  assign bus.RedirectPc_EX  = taken_c ? target_c : '0;
  assign bus.Valid_EX       = valid_q;
  assign bus.Link_EX        = link_q;
  assign bus.LinkVal_EX     = link_q ? pc_plus4_c : '0;
  assign bus.BranchCnt      = branch_cnt_q;
  assign bus.TakenCnt       = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ex.sv
// Directed bench for branch_resolve_ex: each step pushes the expected EX view
// to a scoreboard, clocks once, then pops and compares.
module tb_branch_resolve_ex;

  localparam int unsigned CW = 4;

  logic clk;
  logic reset;

  branch_resolve_ex_if #(.CNT_W(CW)) bus();

  branch_resolve_ex #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic        taken;
    logic [31:0] rpc;
    logic        valid;
    logic        link;
    logic [31:0] lv;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;
  int   step_id;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s@%0d: observed %0h expected %0h", tag, id, obs, exp);
    end
  endtask

  task automatic cnt_chk(input int id, input logic [31:0] eb, input logic [31:0] et);
    chk("BranchCnt", id, 32'(bus.BranchCnt), eb);
    chk("TakenCnt",  id, 32'(bus.TakenCnt),  et);
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [15:0] imm,
                      input logic [2:0] op, input logic lk, input logic [31:0] a,
                      input logic [31:0] b, input logic stall,
                      input logic e_tk, input logic [31:0] e_rpc, input logic e_v,
                      input logic e_lk, input logic [31:0] e_lv);
    exp_t e;
    exp_t got;
    bus.Valid_ID = v;   bus.Pc_ID   = pc; bus.Imm_ID  = imm; bus.BpCtl_ID = op;
    bus.Link_ID  = lk;  bus.SrcA_ID = a;  bus.SrcB_ID = b;   bus.AnyStall = stall;
    e.id = step_id; e.taken = e_tk; e.rpc = e_rpc; e.valid = e_v; e.link = e_lk; e.lv = e_lv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("BranchTaken_EX", got.id, 32'(bus.BranchTaken_EX), 32'(got.taken));
    chk("RedirectPc_EX",  got.id, bus.RedirectPc_EX,       got.rpc);
    chk("Valid_EX",       got.id, 32'(bus.Valid_EX),       32'(got.valid));
    chk("Link_EX",        got.id, 32'(bus.Link_EX),        32'(got.link));
    chk("LinkVal_EX",     got.id, bus.LinkVal_EX,          got.lv);
    step_id++;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; step_id = 0;
    reset = 1'b1;
    bus.AnyStall = 1'b0; bus.Valid_ID = 1'b0; bus.Pc_ID = '0; bus.Imm_ID = '0;
    bus.BpCtl_ID = '0; bus.Link_ID = 1'b0; bus.SrcA_ID = '0; bus.SrcB_ID = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_Valid_EX", 0, 32'(bus.Valid_EX), 32'd0);
    chk("rst_Taken",    0, 32'(bus.BranchTaken_EX), 32'd0);
    chk("rst_Rpc",      0, bus.RedirectPc_EX, 32'd0);
    chk("rst_Link",     0, 32'(bus.Link_EX), 32'd0);
    chk("rst_LinkVal",  0, bus.LinkVal_EX, 32'd0);
    cnt_chk(0, 0, 0);
    #9 reset = 1'b1;

    // BEQ taken, then the following instruction is squashed
    step(1, 32'h100, 16'h0004, 3'b001, 0, 5, 5, 0,  1, 32'h114, 1, 0, 0);
    step(1, 32'h104, 16'h0000, 3'b000, 1, 0, 0, 0,  0, 0,       0, 0, 0);
    cnt_chk(step_id, 1, 1);
    // BNE not taken, next instruction admitted
    step(1, 32'h200, 16'h0004, 3'b010, 0, 7, 7, 0,  0, 0,       1, 0, 0);
    step(1, 32'h204, 16'h0000, 3'b000, 0, 0, 0, 0,  0, 0,       1, 0, 0);
    cnt_chk(step_id, 2, 1);
    // BGEZ with negative offset
    step(1, 32'h040, 16'hFFFE, 3'b110, 0, 0, 0, 0,  1, 32'h3C,  1, 0, 0);
    step(0, 32'h044, 16'h0000, 3'b000, 0, 0, 0, 0,  0, 0,       0, 0, 0);
    cnt_chk(step_id, 3, 2);
    // JR with link, squashed follower drops its link
    step(1, 32'h080, 16'h0000, 3'b111, 1, 32'h2000, 0, 0,  1, 32'h2000, 1, 1, 32'h84);
    step(1, 32'h300, 16'h0000, 3'b000, 1, 0, 0, 0,  0, 0,       0, 0, 0);
    cnt_chk(step_id, 4, 3);
    // Signed single-operand conditions
    step(1, 32'h700, 16'h0001, 3'b101, 0, 32'hFFFF_FFFF, 0, 0,  1, 32'h708, 1, 0, 0);
    step(1, 32'h704, 16'h0000, 3'b000, 0, 0, 0, 0,  0, 0,       0, 0, 0);
    cnt_chk(step_id, 5, 4);
    step(1, 32'h710, 16'h0004, 3'b100, 0, 32'h8000_0000, 0, 0,  0, 0, 1, 0, 0);
    step(1, 32'h720, 16'h0004, 3'b011, 0, 32'h1, 0, 0,  0, 0,   1, 0, 0);
    step(1, 32'h730, 16'h0004, 3'b001, 0, 1, 2, 0,  0, 0,       1, 0, 0);
    cnt_chk(step_id, 7, 4);
    // Taken BEQ held by a 3-cycle stall: one redirect pulse, held ID squashed
    step(1, 32'h400, 16'h0010, 3'b001, 0, 1, 1, 0,  1, 32'h444, 1, 0, 0);
    step(1, 32'h404, 16'h0000, 3'b000, 1, 0, 0, 1,  0, 0,       1, 0, 0);
    step(1, 32'h404, 16'h0000, 3'b000, 1, 0, 0, 1,  0, 0,       1, 0, 0);
    step(1, 32'h404, 16'h0000, 3'b000, 1, 0, 0, 1,  0, 0,       1, 0, 0);
    cnt_chk(step_id, 8, 4);
    step(1, 32'h404, 16'h0000, 3'b000, 1, 0, 0, 0,  0, 0,       0, 0, 0);
    cnt_chk(step_id, 9, 5);
    // Async reset mid-cycle during a stalled taken branch
    step(1, 32'h500, 16'h0000, 3'b001, 0, 2, 2, 0,  1, 32'h504, 1, 0, 0);
    step(1, 32'h504, 16'h0000, 3'b000, 0, 0, 0, 1,  0, 0,       1, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_Taken", step_id, 32'(bus.BranchTaken_EX), 32'd0);
    chk("arst_Valid", step_id, 32'(bus.Valid_EX), 32'd0);
    chk("arst_Rpc",   step_id, bus.RedirectPc_EX, 32'd0);
    cnt_chk(step_id, 0, 0);
    @(posedge clk);
    #1;
    chk("arst_hold_Valid", step_id, 32'(bus.Valid_EX), 32'd0);
    reset = 1'b1;
    step(1, 32'h600, 16'h0000, 3'b000, 1, 0, 0, 0,  0, 0,       1, 1, 32'h604);
    cnt_chk(step_id, 0, 0);
    // Saturation with 4-bit counters
    for (int i = 0; i < 20; i++) begin
      step(1, 32'h1000 + 32'(i) * 32'd16, 16'h0000, 3'b001, 0, 32'(i), 32'(i), 0,
           1, 32'h1004 + 32'(i) * 32'd16, 1, 0, 0);
      step(1, 32'h1008 + 32'(i) * 32'd16, 16'h0000, 3'b000, 0, 0, 0, 0,
           0, 0, 0, 0, 0);
      if (i == 9)  cnt_chk(step_id, 10, 10);
      if (i == 14) cnt_chk(step_id, 15, 15);
    end
    cnt_chk(step_id, 15, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ex.md
Name: branch_resolve_ex

Overview:
- Execute-stage branch resolution unit for the 5-stage pipelined MIPS core.
- Registers decoded branch/jump info from decode at the ID/EX boundary and evaluates the branch condition in EX.
- Drives the redirect inputs of fetch (RedirectPc_EX, BranchTaken_EX) and squashes the wrong-path instruction behind a taken branch.
- No delay slot. Link value is Pc+4.

Parameters:
CNT_W, 16, width of saturating branch/taken statistics counters

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; all state clears while low
AnyStall  input  1  global pipeline stall; EX registers hold when 1
Valid_ID  input  1  decode holds a real instruction
Pc_ID  input  32  PC of the instruction in decode
Imm_ID  input  16  immediate from decode (branch offset, words)
BpCtl_ID  input  3  branch op: 000 none, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ, 101 BLTZ, 110 BGEZ, 111 JR
Link_ID  input  1  instruction writes link value
SrcA_ID  input  32  rs operand (forwarded)
SrcB_ID  input  32  rt operand (forwarded)
BranchTaken_EX  output  1  one-shot redirect request to fetch
RedirectPc_EX  output  32  redirect target, valid when BranchTaken_EX=1
Valid_EX  output  1  EX holds a real (unsquashed) instruction
LinkVal_EX  output  32  Pc_EX+4, qualified by Link_EX
Link_EX  output  1  registered Link_ID & Valid
BranchCnt  output  CNT_W  count of branch ops retired from EX
TakenCnt  output  CNT_W  count of taken branches retired from EX

Behaviour:
- Reset (reset=0, async): Valid_EX, Link_EX, BranchTaken_EX, RedirectPc_EX, LinkVal_EX, both counters, and the RedirectIssued/SquashPending flags all go to 0 immediately. RedirectPc_EX is forced to 0 when not taken.
- Advance: on a rising edge with AnyStall=0, the EX registers load the ID fields. Valid_EX <= Valid_ID & ~Squash, where Squash = (BranchTaken_EX | SquashPending).
- Squashed capture: Link_EX=0 and BpCtl_EX=000, so a squashed instruction is a bubble.
- Hold: with AnyStall=1, all EX registers hold.
- Condition, evaluated combinationally from EX registers on signed 32-bit compares:
  - BEQ: A==B
  - BNE: A!=B
  - BLEZ: A<=0
  - BGTZ: A>0
  - BLTZ: A<0
  - BGEZ: A>=0
  - JR: always taken
  - 000: never taken
- Target:
  - Conditional branches: Pc_EX + 4 + (sign_extend(Imm_EX) << 2), modulo 2^32 (wrap-around is silent).
  - JR: SrcA_EX.
- Cond = Valid_EX & condition.
- BranchTaken_EX = Cond & ~RedirectIssued. Latency: 1 cycle after the branch is captured from ID.
- RedirectIssued: set on an edge where BranchTaken_EX=1 and AnyStall=1; cleared on any advancing edge. Fetch therefore sees exactly one redirect pulse per taken branch, however long the stall.
- SquashPending: set on an edge where BranchTaken_EX=1 and AnyStall=1; cleared on the next advancing edge, after it has squashed the capture. The instruction held in ID during the stall is therefore never admitted.
- Counters: on an advancing edge, if Valid_EX and BpCtl_EX!=000, increment BranchCnt; if additionally Cond, increment TakenCnt. Both saturate at all-ones and never wrap.
- Simultaneous taken branch in EX and branch in ID: the ID branch is squashed; its condition is never evaluated and it is never counted.
- Reset deasserted mid-stall: no pending redirect or squash survives reset.

Test Plan:
- BEQ taken:
  - Stimulus: Pc_ID=0x100, Imm=0x0004, SrcA=SrcB=5, Valid_ID=1, advance.
  - Response: next cycle BranchTaken_EX=1, RedirectPc_EX=0x114. The following ID instruction is captured with Valid_EX=0.
- Not taken plus negative offset:
  - Stimulus A: BNE with A=B=7. Response: BranchTaken_EX stays 0, the next instruction enters with Valid_EX=1.
  - Stimulus B: BGEZ with A=0, Pc=0x40, Imm=0xFFFE. Response: RedirectPc_EX=0x3C.
- JR with link:
  - Stimulus: BpCtl=111, SrcA=0x2000, Link_ID=1, Pc=0x80.
  - Response: RedirectPc_EX=0x2000, Link_EX=1, LinkVal_EX=0x84.
- Stall during taken branch:
  - Stimulus: AnyStall=1 for 3 cycles while a taken BEQ sits in EX.
  - Response: BranchTaken_EX high for exactly 1 cycle. After the stall drops, the held ID instruction enters with Valid_EX=0 and TakenCnt increments by 1 only.
- Async reset:
  - Stimulus: drive reset low mid-cycle while a taken branch is in EX.
  - Response: BranchTaken_EX=0, Valid_EX=0, counters=0 before the next clock edge. After release the first instruction is not squashed.
- Saturation:
  - Stimulus: CNT_W=4, 20 taken branches.
  - Response: BranchCnt=TakenCnt=0xF, with no wrap.
